ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  MIPS execute stage plus EX/MEM pipeline register; sits between the ID/EX register and the data-memory stage.
//  Decodes ALU control, applies operand forwarding and drives the 32-bit ALU (ALU_MIPS).
//  Registers result, zero, store data, branch decision and control bits for the MEM stage.
//  Handles stall (hold) and flush (bubble).
// PARAMETERS
//  DW       32  datapath width; ALU is fixed at 32, so only 32 is supported
//  RW        5  register-index width
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  id_valid     in   1   ID/EX slot holds a real instruction
//  id_rs_data   in   DW  rs register value
//  id_rt_data   in   DW  rt register value
//  id_imm       in   DW  sign-extended immediate
//  id_pc4       in   DW  PC+4 of the instruction
//  id_wreg      in   RW  destination register, already rt/rd selected
//  id_alu_op    in   2   00 add, 01 sub, 10 R-type funct, 11 illegal
//  id_funct     in   6   instruction funct field
//  id_alu_src   in   1   1: operand B = id_imm
//  id_ctl       in   4   {branch, mem_read, mem_write, reg_write}
//  id_mem2reg   in   1   writeback selects memory data
//  fwd_a        in   2   00 rs_data, 10 ex_alu_result, 01 wb_data
//  fwd_b        in   2   same encoding, applied to rt before the alu_src mux
//  wb_data      in   DW  MEM/WB writeback value
//  stall        in   1   hold every EX/MEM register
//  flush        in   1   load a bubble
//  ex_valid     out  1   EX/MEM holds a real instruction
//  ex_alu_result out DW  registered ALU result
//  ex_zero      out  1   registered ALU zero flag
//  ex_store_data out DW  forwarded rt value, used for sw
//  ex_wreg      out RW   registered destination register
//  ex_ctl       out  4   registered {branch, mem_read, mem_write, reg_write}
//  ex_mem2reg   out  1   registered mem2reg
//  ex_br_taken  out  1   branch & zero & valid
//  ex_br_target out DW   id_pc4 + (id_imm << 2), registered
//  ex_illegal   out  1   unsupported op or funct, sticky per slot
// BEHAVIOUR
//  - Reset: every output is 0 asynchronously, including ex_valid.
//  - Latency: 1 cycle. ID inputs sampled at edge N appear at the outputs after edge N.
//  - ALU control decode:
//      alu_op 00 -> 0010
//      alu_op 01 -> 0110
//      alu_op 10, funct 100000 -> 0010 (add)
//      alu_op 10, funct 100010 -> 0110 (sub)
//      alu_op 10, funct 100110 -> 0000 (xor)
//      alu_op 10, funct 100101 -> 0001 (or)
//  - Any other op/funct: drive ctrl 0010 (never X into the ALU), set ex_illegal=1, force ex_ctl=0.
//  - Forwarding mux: fwd code 11 is treated as 00.
//  - Operand B = alu_src ? imm : forwarded rt. Store data is always forwarded rt.
//  - Arithmetic: modulo 2^32, no overflow trap. ex_br_target wraps mod 2^32.
//  - Priority: reset > flush > stall > load.
//      flush: ex_valid=0, ex_ctl=0, ex_br_taken=0, ex_illegal=0; data fields don't-care but hold.
//      stall: all registers hold, including ex_br_taken.
//      flush & stall together: flush wins.
//  - id_valid=0 with neither flush nor stall: load as a bubble (same as flush).
//  - Reset asserted mid-operation clears the slot at once. The first valid output follows
//    the first load edge after rst_n rises.
// STRUCTURE
//  - Shared package: ALU ctrl codes (ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_XOR=4'b0000,
//    ALU_OR=4'b0001), alu_op encodings, funct constants, fwd select codes, ctl bit indices.
//  - Sub-module alu_ctrl_dec: combinational {alu_op, funct} -> {ctrl[3:0], illegal}.
//  - One instance of the existing 32-bit ALU (ALU_MIPS). Forwarding muxes and the
//    EX/MEM register are in this module.
// TESTING
//  1 rst_n=0 mid-stream -> all outputs 0 immediately; rst_n=1 then an add -> result valid
//    after the next edge.
//  2 R-type add: rs=5, rt=7, funct 100000 -> ex_alu_result=12, ex_zero=0.
//    funct 100010 with rs=rt=9 -> result=0, zero=1.
//  3 Forwarding: fwd_a=10 with ex_alu_result=0x10, fwd_b=01 with wb_data=3, or funct
//    -> result=0x13. ex_store_data=3.
//  4 beq: alu_op=01, rs=rt=4, branch=1, pc4=0x100, imm=-2 -> ex_br_taken=1, target=0xF8.
//    With rt=5 -> ex_br_taken=0.
//  5 stall held 3 cycles -> outputs unchanged. flush with stall=1 -> ex_valid=0, ex_ctl=0
//    next edge.
//  6 alu_op=10, funct 101010 -> ex_illegal=1, ex_ctl=0, no X on any output.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared constants for the MIPS execute stage: ALU control codes, alu_op
// encodings, R-type funct values, forwarding selects and control-bit indices.
package ex_mem_stage_pkg;

    // 4-bit control codes understood by ALU_MIPS
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    // alu_op field produced by the main decoder
    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_ILL   = 2'b11
    } aluOp_e;

    // R-type funct values handled by this stage
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    // Forwarding selects; 2'b11 behaves like FWD_REG
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_EX  = 2'b10;

    // Bit positions inside the 4-bit {branch, mem_read, mem_write, reg_write} bundle
    localparam int CTL_BRANCH    = 3;
    localparam int CTL_MEM_READ  = 2;
    localparam int CTL_MEM_WRITE = 1;
    localparam int CTL_REG_WRITE = 0;

    // Operand forwarding mux shared by both ALU inputs
    function automatic logic [31:0] fwdMux(input logic [1:0]  sel,
                                           input logic [31:0] regVal,
                                           input logic [31:0] exVal,
                                           input logic [31:0] wbVal);
        logic [31:0] outVal;
        case (sel)
            FWD_EX:  outVal = exVal;
            FWD_WB:  outVal = wbVal;
            default: outVal = regVal;
        endcase
        return outVal;
    endfunction

endpackage

// File: rtl/ALU_MIPS.sv
// 32-bit MIPS ALU: add, sub, xor, or selected by a 4-bit control code.
// Arithmetic wraps modulo 2^32 with no overflow indication.
module ALU_MIPS
    import ex_mem_stage_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  ctrl_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    // Operation select; unknown codes fall back to add
    always_comb begin
        case (ctrl_i)
            ALU_SUB: result_o = a_i - b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_OR:  result_o = a_i | b_i;
            default: result_o = a_i + b_i;
        endcase
        zero_o = (result_o == 32'd0);
    end

endmodule

// File: rtl/ex_mem_stage_alu_ctrl_dec.sv
// ALU control decoder: maps {alu_op, funct} onto an ALU control code and
// flags encodings this stage does not implement. Unsupported encodings still
// produce a defined add code so the ALU never sees X.
module alu_ctrl_dec
    import ex_mem_stage_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] ctrl_o,
    output logic       illegal_o
);

    // Combinational decode with safe add default for anything unrecognised
    always_comb begin
        ctrl_o    = ALU_ADD;
        illegal_o = 1'b0;
        case (alu_op_i)
            ALU_OP_ADD: ctrl_o = ALU_ADD;
            ALU_OP_SUB: ctrl_o = ALU_SUB;
            ALU_OP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: ctrl_o = ALU_ADD;
                    FUNCT_SUB: ctrl_o = ALU_SUB;
                    FUNCT_XOR: ctrl_o = ALU_XOR;
                    FUNCT_OR:  ctrl_o = ALU_OR;
                    default:   illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// MIPS execute stage and EX/MEM pipeline register. Forwards operands, runs
// the ALU, computes the branch decision and target, and registers everything
// for the MEM stage with stall (hold) and flush (bubble) handling.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic [RW-1:0] id_wreg,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic          id_alu_src,
    input  logic [3:0]    id_ctl,
    input  logic          id_mem2reg,
    input  logic [1:0]    fwd_a,
    input  logic [1:0]    fwd_b,
    input  logic [DW-1:0] wb_data,
    input  logic          stall,
    input  logic          flush,
    output logic          ex_valid,
    output logic [DW-1:0] ex_alu_result,
    output logic          ex_zero,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wreg,
    output logic [3:0]    ex_ctl,
    output logic          ex_mem2reg,
    output logic          ex_br_taken,
    output logic [DW-1:0] ex_br_target,
    output logic          ex_illegal
);

    logic [3:0]    aluCtrl;
    logic          decIllegal;
    logic [31:0]   opA;
    logic [31:0]   rtFwd;
    logic [31:0]   opB;
    logic [31:0]   aluResult;
    logic          aluZero;

    logic          valid_q,     valid_d;
    logic [DW-1:0] result_q,    result_d;
    logic          zero_q,      zero_d;
    logic [DW-1:0] storeData_q, storeData_d;
    logic [RW-1:0] wreg_q,      wreg_d;
    logic [3:0]    ctl_q,       ctl_d;
    logic          mem2reg_q,   mem2reg_d;
    logic          brTaken_q,   brTaken_d;
    logic [DW-1:0] brTarget_q,  brTarget_d;
    logic          illegal_q,   illegal_d;

    alu_ctrl_dec u_dec (
        .alu_op_i  (id_alu_op),
        .funct_i   (id_funct),
        .ctrl_o    (aluCtrl),
        .illegal_o (decIllegal)
    );

    // Forwarded operands; store data always takes the forwarded rt
    always_comb begin
        opA   = fwdMux(fwd_a, id_rs_data, result_q, wb_data);
        rtFwd = fwdMux(fwd_b, id_rt_data, result_q, wb_data);
        opB   = id_alu_src ? id_imm : rtFwd;
    end

    ALU_MIPS u_alu (
        .a_i      (opA),
        .b_i      (opB),
        .ctrl_i   (aluCtrl),
        .result_o (aluResult),
        .zero_o   (aluZero)
    );

    // Next-state selection: flush (or an empty ID slot) clears the control
    // side and leaves data fields holding; stall holds everything
    always_comb begin
        valid_d     = valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        storeData_d = storeData_q;
        wreg_d      = wreg_q;
        ctl_d       = ctl_q;
        mem2reg_d   = mem2reg_q;
        brTaken_d   = brTaken_q;
        brTarget_d  = brTarget_q;
        illegal_d   = illegal_q;
        if (flush || (!stall && !id_valid)) begin
            valid_d   = 1'b0;
            ctl_d     = 4'b0000;
            brTaken_d = 1'b0;
            illegal_d = 1'b0;
        end else if (!stall) begin
            valid_d     = 1'b1;
            result_d    = aluResult;
            zero_d      = aluZero;
            storeData_d = rtFwd;
            wreg_d      = id_wreg;
            ctl_d       = decIllegal ? 4'b0000 : id_ctl;
            mem2reg_d   = id_mem2reg;
            brTaken_d   = !decIllegal && id_ctl[CTL_BRANCH] && aluZero;
            brTarget_d  = id_pc4 + (id_imm << 2);
            illegal_d   = decIllegal;
        end
    end

    // EX/MEM register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            storeData_q <= '0;
            wreg_q      <= '0;
            ctl_q       <= 4'b0000;
            mem2reg_q   <= 1'b0;
            brTaken_q   <= 1'b0;
            brTarget_q  <= '0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            storeData_q <= storeData_d;
            wreg_q      <= wreg_d;
            ctl_q       <= ctl_d;
            mem2reg_q   <= mem2reg_d;
            brTaken_q   <= brTaken_d;
            brTarget_q  <= brTarget_d;
            illegal_q   <= illegal_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_result = result_q;
    assign ex_zero       = zero_q;
    assign ex_store_data = storeData_q;
    assign ex_wreg       = wreg_q;
    assign ex_ctl        = ctl_q;
    assign ex_mem2reg    = mem2reg_q;
    assign ex_br_taken   = brTaken_q;
    assign ex_br_target  = brTarget_q;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the EX/MEM slot.
module tb_ex_mem_stage;

    typedef struct {
        logic        valid;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [31:0] wb;
        logic [4:0]  wreg;
        logic [1:0]  aluOp;
        logic [5:0]  funct;
        logic        aluSrc;
        logic [3:0]  ctl;
        logic        mem2reg;
        logic [1:0]  fwdA;
        logic [1:0]  fwdB;
        logic        stall;
        logic        flush;
    } stim_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [31:0] id_pc4;
    logic [4:0]  id_wreg;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src;
    logic [3:0]  id_ctl;
    logic        id_mem2reg;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] wb_data;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic        ex_zero;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wreg;
    logic [3:0]  ex_ctl;
    logic        ex_mem2reg;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic        ex_illegal;

    int checkCount = 0;
    int failCount  = 0;

    // Behavioural model of the EX/MEM slot
    logic        mValid;
    logic [31:0] mResult;
    logic        mZero;
    logic [31:0] mStore;
    logic [4:0]  mWreg;
    logic [3:0]  mCtl;
    logic        mMem2reg;
    logic        mBrTaken;
    logic [31:0] mBrTarget;
    logic        mIllegal;

    ex_mem_stage #(.DW(32), .RW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm        (id_imm),
        .id_pc4        (id_pc4),
        .id_wreg       (id_wreg),
        .id_alu_op     (id_alu_op),
        .id_funct      (id_funct),
        .id_alu_src    (id_alu_src),
        .id_ctl        (id_ctl),
        .id_mem2reg    (id_mem2reg),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .wb_data       (wb_data),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_zero       (ex_zero),
        .ex_store_data (ex_store_data),
        .ex_wreg       (ex_wreg),
        .ex_ctl        (ex_ctl),
        .ex_mem2reg    (ex_mem2reg),
        .ex_br_taken   (ex_br_taken),
        .ex_br_target  (ex_br_target),
        .ex_illegal    (ex_illegal)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check is counted here
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic stim_t nopStim();
        stim_t s;
        s.valid = 1'b0; s.rs = '0; s.rt = '0; s.imm = '0; s.pc4 = '0; s.wb = '0;
        s.wreg = '0; s.aluOp = 2'b00; s.funct = '0; s.aluSrc = 1'b0; s.ctl = '0;
        s.mem2reg = 1'b0; s.fwdA = 2'b00; s.fwdB = 2'b00; s.stall = 1'b0; s.flush = 1'b0;
        return s;
    endfunction

    function automatic stim_t instr(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [31:0] rs, input logic [31:0] rt, input logic [3:0] ctl);
        stim_t s = nopStim();
        s.valid = 1'b1; s.aluOp = op; s.funct = fn; s.rs = rs; s.rt = rt; s.ctl = ctl;
        s.wreg = 5'd3; s.pc4 = 32'h0000_0040;
        return s;
    endfunction

    task automatic modelReset();
        mValid = 0; mResult = 0; mZero = 0; mStore = 0; mWreg = 0;
        mCtl = 0; mMem2reg = 0; mBrTaken = 0; mBrTarget = 0; mIllegal = 0;
    endtask

    // Slot semantics: what the MEM stage should see after this edge
    task automatic modelStep(input stim_t s);
        logic [31:0] a, rtv, b, r;
        logic        bad;
        if (s.flush || (!s.stall && !s.valid)) begin
            mValid = 0; mCtl = 0; mBrTaken = 0; mIllegal = 0;
        end else if (!s.stall) begin
            a   = (s.fwdA == 2'b10) ? mResult : (s.fwdA == 2'b01) ? s.wb : s.rs;
            rtv = (s.fwdB == 2'b10) ? mResult : (s.fwdB == 2'b01) ? s.wb : s.rt;
            b   = s.aluSrc ? s.imm : rtv;
            bad = 0;
            if (s.aluOp == 2'b00)      r = a + b;
            else if (s.aluOp == 2'b01) r = a - b;
            else if (s.aluOp == 2'b10 && s.funct == 6'd32) r = a + b;
            else if (s.aluOp == 2'b10 && s.funct == 6'd34) r = a - b;
            else if (s.aluOp == 2'b10 && s.funct == 6'd38) r = a ^ b;
            else if (s.aluOp == 2'b10 && s.funct == 6'd37) r = a | b;
            else begin r = a + b; bad = 1; end
            mValid    = 1;
            mResult   = r;
            mZero     = (r == 0);
            mStore    = rtv;
            mWreg     = s.wreg;
            mCtl      = bad ? 4'd0 : s.ctl;
            mMem2reg  = s.mem2reg;
            mBrTaken  = !bad && s.ctl[3] && (r == 0);
            mBrTarget = s.pc4 + s.imm * 4;
            mIllegal  = bad;
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".valid"},   {31'd0, ex_valid},    {31'd0, mValid});
        checkOutput({tag, ".result"},  ex_alu_result,        mResult);
        checkOutput({tag, ".zero"},    {31'd0, ex_zero},     {31'd0, mZero});
        checkOutput({tag, ".store"},   ex_store_data,        mStore);
        checkOutput({tag, ".wreg"},    {27'd0, ex_wreg},     {27'd0, mWreg});
        checkOutput({tag, ".ctl"},     {28'd0, ex_ctl},      {28'd0, mCtl});
        checkOutput({tag, ".brTaken"}, {31'd0, ex_br_taken}, {31'd0, mBrTaken});
        checkOutput({tag, ".brTarget"}, ex_br_target,        mBrTarget);
        checkOutput({tag, ".illegal"}, {31'd0, ex_illegal},  {31'd0, mIllegal});
        if (mValid)
            checkOutput({tag, ".mem2reg"}, {31'd0, ex_mem2reg}, {31'd0, mMem2reg});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".valid"},  {31'd0, ex_valid}, 32'd0);
        checkOutput({tag, ".result"}, ex_alu_result, 32'd0);
        checkOutput({tag, ".misc"},   {20'd0, ex_zero, ex_wreg, ex_ctl, ex_mem2reg, ex_br_taken}, 32'd0);
        checkOutput({tag, ".store"},  ex_store_data, 32'd0);
        checkOutput({tag, ".target"}, ex_br_target, 32'd0);
        checkOutput({tag, ".illegal"}, {31'd0, ex_illegal}, 32'd0);
    endtask

    // Drive one cycle of ID/EX inputs, clock it in, then compare to the model
    task automatic applyStimulus(input stim_t s, input string tag);
        @(negedge clk);
        id_valid = s.valid;  id_rs_data = s.rs;   id_rt_data = s.rt;  id_imm = s.imm;
        id_pc4 = s.pc4;      wb_data = s.wb;      id_wreg = s.wreg;   id_alu_op = s.aluOp;
        id_funct = s.funct;  id_alu_src = s.aluSrc; id_ctl = s.ctl;   id_mem2reg = s.mem2reg;
        fwd_a = s.fwdA;      fwd_b = s.fwdB;      stall = s.stall;    flush = s.flush;
        @(posedge clk);
        #1;
        modelStep(s);
        compareAll(tag);
    endtask

    function automatic stim_t randStim();
        stim_t s;
        logic [5:0] legal [4];
        legal[0] = 6'd32; legal[1] = 6'd34; legal[2] = 6'd38; legal[3] = 6'd37;
        s.valid   = ($urandom_range(0, 7) != 0);
        s.rs      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        s.rt      = ($urandom_range(0, 3) == 0) ? s.rs : $urandom;
        s.imm     = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
        s.pc4     = $urandom;
        s.wb      = $urandom;
        s.wreg    = 5'($urandom);
        s.aluOp   = 2'($urandom);
        s.funct   = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal[$urandom_range(0, 3)];
        s.aluSrc  = 1'($urandom);
        s.ctl     = 4'($urandom);
        s.mem2reg = 1'($urandom);
        s.fwdA    = 2'($urandom);
        s.fwdB    = 2'($urandom);
        s.stall   = ($urandom_range(0, 7) == 0);
        s.flush   = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        rst_n = 1'b0;
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_pc4 = 0; wb_data = 0;
        id_wreg = 0; id_alu_op = 0; id_funct = 0; id_alu_src = 0; id_ctl = 0; id_mem2reg = 0;
        fwd_a = 0; fwd_b = 0; stall = 0; flush = 0;
        modelReset();
        #12;
        checkAllZero("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: reset mid-stream clears immediately, first load after release is valid
        applyStimulus(instr(2'b00, 6'd0, 32'd20, 32'd22, 4'b0001), "t1_pre");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAllZero("t1_rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(instr(2'b00, 6'd0, 32'd1, 32'd2, 4'b0001), "t1_add");
        checkOutput("t1_result", ex_alu_result, 32'd3);

        // Test 2: R-type add and sub-to-zero
        applyStimulus(instr(2'b10, 6'b100000, 32'd5, 32'd7, 4'b0001), "t2_add");
        checkOutput("t2_add_result", ex_alu_result, 32'd12);
        checkOutput("t2_add_zero", {31'd0, ex_zero}, 32'd0);
        applyStimulus(instr(2'b10, 6'b100010, 32'd9, 32'd9, 4'b0001), "t2_sub");
        checkOutput("t2_sub_zero", {31'd0, ex_zero}, 32'd1);

        // Test 3: forwarding from EX/MEM on A and from writeback on B
        applyStimulus(instr(2'b00, 6'd0, 32'h10, 32'h0, 4'b0001), "t3_seed");
        s = instr(2'b10, 6'b100101, 32'hDEAD, 32'hBEEF, 4'b0001);
        s.fwdA = 2'b10; s.fwdB = 2'b01; s.wb = 32'd3;
        applyStimulus(s, "t3_fwd");
        checkOutput("t3_result", ex_alu_result, 32'h13);
        checkOutput("t3_store", ex_store_data, 32'd3);

        // Test 4: beq taken and not taken
        s = instr(2'b01, 6'd0, 32'd4, 32'd4, 4'b1000);
        s.pc4 = 32'h100; s.imm = 32'hFFFF_FFFE;
        applyStimulus(s, "t4_taken");
        checkOutput("t4_taken", {31'd0, ex_br_taken}, 32'd1);
        checkOutput("t4_target", ex_br_target, 32'hF8);
        s.rt = 32'd5;
        applyStimulus(s, "t4_nottaken");
        checkOutput("t4_nottaken", {31'd0, ex_br_taken}, 32'd0);

        // Test 5: stall holds for three cycles, then flush beats stall
        applyStimulus(instr(2'b10, 6'b100110, 32'hF0F0, 32'h0FF0, 4'b0101), "t5_load");
        for (int i = 0; i < 3; i++) begin
            s = randStim();
            s.stall = 1'b1; s.flush = 1'b0;
            applyStimulus(s, "t5_stall");
        end
        checkOutput("t5_hold", ex_alu_result, 32'hFF00);
        s = randStim();
        s.stall = 1'b1; s.flush = 1'b1; s.valid = 1'b1;
        applyStimulus(s, "t5_flush");
        checkOutput("t5_flush_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("t5_flush_ctl", {28'd0, ex_ctl}, 32'd0);

        // Test 6: unsupported funct flags illegal and kills control bits
        applyStimulus(instr(2'b10, 6'b101010, 32'd6, 32'd6, 4'b1111), "t6_ill");
        checkOutput("t6_illegal", {31'd0, ex_illegal}, 32'd1);
        checkOutput("t6_ctl", {28'd0, ex_ctl}, 32'd0);
        checkOutput("t6_noX", {31'd0, $isunknown({ex_valid, ex_alu_result, ex_zero, ex_store_data,
                    ex_wreg, ex_ctl, ex_mem2reg, ex_br_taken, ex_br_target, ex_illegal})}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(randStim(), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
